mem_access_stage: RTL and testbench

Memory-access pipeline stage of the RV32I core, between the EX/MEM pipeline register and the MEM/WB register. It accepts one load or store per operation, drives the data-cache request/response handshake, and generates byte enables and store-data replication. Load data is aligned and sign- or zero-extended according to the `dcachemux::rdata_sel_t` encoding, so writeback receives final register data. The stage stalls the upstream pipeline while a cache access is outstanding and flags misaligned accesses without touching the cache.

---
 rtl/mem_access_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: drives the data-cache handshake,
// forms byte enables / store replication, aligns and extends loads.
// Ports: in_* from EX/MEM, dcache_* to/from the data cache,
// out_* to MEM/WB, stall to upstream, stall_cycles perf counter.
module mem_access_stage #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [2:0]        in_rdata_sel,
  input  logic [1:0]        in_st_size,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_wdata,
  output logic              stall,
  output logic              dcache_read,
  output logic              dcache_write,
  output logic [31:0]       dcache_address,
  output logic [3:0]        dcache_mbe,
  output logic [31:0]       dcache_wdata,
  input  logic [31:0]       dcache_rdata,
  input  logic              dcache_resp,
  output logic              out_valid,
  output logic [31:0]       out_load_data,
  output logic              out_misaligned,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  localparam logic [2:0] SEL_LW  = 3'd0;
  localparam logic [2:0] SEL_LHU = 3'd1;
  localparam logic [2:0] SEL_LH  = 3'd2;
  localparam logic [2:0] SEL_LBU = 3'd3;
  localparam logic [2:0] SEL_LB  = 3'd4;

  state_t      state;
  state_t      state_nx;
  logic        stall_c;
  logic        accept;
  logic        misal;
  logic [2:0]  sel;
  logic [3:0]  mbe_nx;
  logic [31:0] wd_nx;
  logic [2:0]  lat_sel;
  logic [1:0]  lat_off;
  logic        lat_ld;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [31:0] ld_data;

  // Loads win when both load and store are flagged.
  always_comb begin
    sel = (in_rdata_sel > SEL_LB) ? SEL_LW : in_rdata_sel;
    misal = 1'b0;
    mbe_nx = 4'b1111;
    wd_nx = in_wdata;
    if (in_load) begin
      case (sel)
        SEL_LW:           misal = |in_addr[1:0];
        SEL_LHU, SEL_LH:  misal = in_addr[0];
        default:          misal = 1'b0;
      endcase
    end else if (in_store) begin
      case (in_st_size)
        2'b00: begin
          misal = 1'b0;
          mbe_nx = 4'b0001 << in_addr[1:0];
          wd_nx = {4{in_wdata[7:0]}};
        end
        2'b01: begin
          misal = in_addr[0];
          mbe_nx = in_addr[1] ? 4'b1100 : 4'b0011;
          wd_nx = {2{in_wdata[15:0]}};
        end
        default: begin
          misal = |in_addr[1:0];
        end
      endcase
    end
    accept = in_valid & (in_load | in_store) & ~misal;
  end

  always_comb begin
    state_nx = state;
    stall_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall_c = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        stall_c = ~dcache_resp;
        if (dcache_resp) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gated so stall reads 0 while reset is held, whatever the inputs.
  assign stall = rst_n & stall_c;

  always_comb begin
    shifted = dcache_rdata >> {lat_off, 3'b000};
    case (lat_sel)
      SEL_LHU: ext = {16'b0, shifted[15:0]};
      SEL_LH:  ext = {{16{shifted[15]}}, shifted[15:0]};
      SEL_LBU: ext = {24'b0, shifted[7:0]};
      SEL_LB:  ext = {{24{shifted[7]}}, shifted[7:0]};
      default: ext = dcache_rdata;
    endcase
    ld_data = lat_ld ? ext : 32'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dcache_read <= 1'b0;
      dcache_write <= 1'b0;
      dcache_address <= '0;
      dcache_mbe <= '0;
      dcache_wdata <= '0;
      out_valid <= 1'b0;
      out_load_data <= '0;
      out_misaligned <= 1'b0;
      stall_cycles <= '0;
      lat_sel <= '0;
      lat_off <= '0;
      lat_ld <= 1'b0;
    end else begin
      state <= state_nx;
      out_valid <= 1'b0;
      if (stall_c && !(&stall_cycles))
        stall_cycles <= stall_cycles + PERF_W'(1);
      unique case (state)
        IDLE: begin
          if (accept) begin
            dcache_read <= in_load;
            dcache_write <= ~in_load;
            dcache_address <= {in_addr[31:2], 2'b00};
            dcache_mbe <= mbe_nx;
            dcache_wdata <= wd_nx;
            lat_sel <= sel;
            lat_off <= in_addr[1:0];
            lat_ld <= in_load;
          end else if (in_valid) begin
            out_valid <= 1'b1;
            out_load_data <= '0;
            out_misaligned <= misal;
          end
        end
        REQ: begin
          if (dcache_resp) begin
            dcache_read <= 1'b0;
            dcache_write <= 1'b0;
            out_valid <= 1'b1;
            out_load_data <= ld_data;
            out_misaligned <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed loads, stores,
// misaligned/non-memory ops and reset during an outstanding access.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_load;
  logic        in_store;
  logic [2:0]  in_rdata_sel;
  logic [1:0]  in_st_size;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        stall;
  logic        dcache_read;
  logic        dcache_write;
  logic [31:0] dcache_address;
  logic [3:0]  dcache_mbe;
  logic [31:0] dcache_wdata;
  logic [31:0] dcache_rdata;
  logic        dcache_resp;
  logic        out_valid;
  logic [31:0] out_load_data;
  logic        out_misaligned;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int errors = 0;
  int exp_stalls = 0;
  logic [32:0] sb_q[$];

  mem_access_stage #(.PERF_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_load(in_load),
    .in_store(in_store),
    .in_rdata_sel(in_rdata_sel),
    .in_st_size(in_st_size),
    .in_addr(in_addr),
    .in_wdata(in_wdata),
    .stall(stall),
    .dcache_read(dcache_read),
    .dcache_write(dcache_write),
    .dcache_address(dcache_address),
    .dcache_mbe(dcache_mbe),
    .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata),
    .dcache_resp(dcache_resp),
    .out_valid(out_valid),
    .out_load_data(out_load_data),
    .out_misaligned(out_misaligned),
    .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_out_valid: got data %h expected none",
                 out_load_data);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("out_load_data", out_load_data, e[31:0]);
        chk("out_misaligned", {31'b0, out_misaligned}, {31'b0, e[32]});
      end
    end
  end

  task automatic drive(input logic ld, input logic st,
                       input logic [2:0] sel, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    in_valid = 1'b1;
    in_load = ld;
    in_store = st;
    in_rdata_sel = sel;
    in_st_size = sz;
    in_addr = a;
    in_wdata = wd;
  endtask

  task automatic mem_op(input logic ld, input logic st,
                        input logic [2:0] sel, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int lat,
                        input logic [31:0] exp_d,
                        input logic [3:0] exp_mbe,
                        input logic [31:0] exp_wd);
    @(posedge clk);
    #1;
    drive(ld, st, sel, sz, a, wd);
    sb_q.push_back({1'b0, exp_d});
    @(negedge clk);
    chk("accept_stall", {31'b0, stall}, 32'd1);
    chk("accept_noreq", {31'b0, dcache_read | dcache_write}, 32'd0);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk);
      #1;
      if (c == lat) begin
        dcache_resp = 1'b1;
        dcache_rdata = rd;
      end
      @(negedge clk);
      chk("req_read", {31'b0, dcache_read}, {31'b0, ld});
      chk("req_write", {31'b0, dcache_write}, {31'b0, ~ld});
      chk("req_addr", dcache_address, {a[31:2], 2'b00});
      chk("req_mbe", {28'b0, dcache_mbe}, {28'b0, exp_mbe});
      chk("req_wdata", dcache_wdata, exp_wd);
      chk("req_stall", {31'b0, stall}, (c < lat) ? 32'd1 : 32'd0);
    end
    exp_stalls += lat;
    @(posedge clk);
    #1;
    dcache_resp = 1'b0;
    dcache_rdata = '0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("req_dropped", {31'b0, dcache_read | dcache_write}, 32'd0);
  endtask

  task automatic quick_op(input logic ld, input logic st,
                          input logic [2:0] sel, input logic [1:0] sz,
                          input logic [31:0] a, input logic mis);
    @(posedge clk);
    #1;
    drive(ld, st, sel, sz, a, 32'h5555_AAAA);
    sb_q.push_back({mis, 32'b0});
    @(negedge clk);
    chk("quick_stall", {31'b0, stall}, 32'd0);
    chk("quick_noreq", {31'b0, dcache_read | dcache_write}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("quick_noreq2", {31'b0, dcache_read | dcache_write}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'bx;
    in_load = 1'bx;
    in_store = 1'bx;
    in_rdata_sel = 'x;
    in_st_size = 'x;
    in_addr = 'x;
    in_wdata = 'x;
    dcache_rdata = 'x;
    dcache_resp = 1'bx;
    #12;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_read", {31'b0, dcache_read}, 32'd0);
    chk("rst_write", {31'b0, dcache_write}, 32'd0);
    chk("rst_addr", dcache_address, 32'd0);
    chk("rst_mbe", {28'b0, dcache_mbe}, 32'd0);
    chk("rst_wdata", dcache_wdata, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_load_data, 32'd0);
    chk("rst_out_mis", {31'b0, out_misaligned}, 32'd0);
    chk("rst_stall_cycles", {16'b0, stall_cycles}, 32'd0);
    in_valid = 1'b0;
    in_load = 1'b0;
    in_store = 1'b0;
    in_rdata_sel = '0;
    in_st_size = '0;
    in_addr = '0;
    in_wdata = '0;
    dcache_rdata = '0;
    dcache_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_stall_cycles", {16'b0, stall_cycles}, 32'd0);

    mem_op(1, 0, 3'b000, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 3,
           32'hDEADBEEF, 4'b1111, 32'h0);
    chk("lw_stall_cycles", {16'b0, stall_cycles}, 32'd3);
    mem_op(1, 0, 3'b100, 2'b00, 32'h103, 32'h0, 32'h80FF1234, 1,
           32'hFFFFFF80, 4'b1111, 32'h0);
    mem_op(1, 0, 3'b011, 2'b00, 32'h103, 32'h0, 32'h80FF1234, 2,
           32'h00000080, 4'b1111, 32'h0);
    mem_op(1, 0, 3'b010, 2'b00, 32'h102, 32'h0, 32'h80FF1234, 1,
           32'hFFFF80FF, 4'b1111, 32'h0);
    mem_op(1, 0, 3'b001, 2'b00, 32'h102, 32'h0, 32'h80FF1234, 1,
           32'h000080FF, 4'b1111, 32'h0);
    mem_op(1, 0, 3'b111, 2'b00, 32'h104, 32'h0, 32'h11223344, 1,
           32'h11223344, 4'b1111, 32'h0);
    mem_op(0, 1, 3'b000, 2'b00, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 2,
           32'h0, 4'b0010, 32'hABABABAB);
    mem_op(0, 1, 3'b000, 2'b01, 32'h202, 32'h00001234, 32'h0, 1,
           32'h0, 4'b1100, 32'h12341234);
    mem_op(0, 1, 3'b000, 2'b11, 32'h208, 32'hCAFEF00D, 32'h0, 1,
           32'h0, 4'b1111, 32'hCAFEF00D);
    mem_op(1, 1, 3'b011, 2'b10, 32'h301, 32'h12345678, 32'h0000A500, 1,
           32'h000000A5, 4'b1111, 32'h12345678);
    chk("accum_stall_cycles", {16'b0, stall_cycles}, exp_stalls);

    quick_op(1, 0, 3'b000, 2'b00, 32'h102, 1'b1);
    quick_op(1, 0, 3'b010, 2'b00, 32'h101, 1'b1);
    quick_op(0, 1, 3'b000, 2'b10, 32'h203, 1'b1);
    quick_op(0, 0, 3'b000, 2'b00, 32'h0, 1'b0);

    @(posedge clk);
    #1;
    drive(1, 0, 3'b000, 2'b00, 32'h300, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_reset_read", {31'b0, dcache_read}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_read", {31'b0, dcache_read}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_stall_cycles", {16'b0, stall_cycles}, 32'd0);
    exp_stalls = 0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_reset_read", {31'b0, dcache_read}, 32'd0);

    mem_op(1, 0, 3'b000, 2'b00, 32'h400, 32'h0, 32'h0BADF00D, 2,
           32'h0BADF00D, 4'b1111, 32'h0);
    chk("final_stall_cycles", {16'b0, stall_cycles}, exp_stalls);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
